knight_anim_sequencer: RTL and testbench
========================================

Name: knight_anim_sequencer

Overview:
- Animation controller and ROM address scheduler for the knight sprite ROM (30x64 px per frame, 3-bit palette index, read on negedge vga_clk).
- Tracks the knight's animation state (idle / walk / attack) and advances the frame once per TICKS_PER_FRAME video frames.
- Converts the current DrawX/DrawY into a ROM address inside the knight's on-screen bounding box, with an optional horizontal mirror.
- Sits between game logic (position, move, attack request) and the shared sprite ROM + palette + pixel register.

Parameters:
- SPR_W, 30: sprite width in px.
- SPR_H, 64: sprite height in px.
- IDLE_FRAMES, 4: frames in the idle strip; stored at ROM frames 0..3.
- WALK_FRAMES, 6: frames in the walk strip; stored at ROM frames 4..9.
- ATTACK_FRAMES, 3: frames in the attack strip; stored at ROM frames 10..12.
- TICKS_PER_FRAME, 6: frame_start pulses per animation frame, >=1.
- ADDR_W, 15: ROM address width; must satisfy 13*SPR_W*SPR_H <= 2^ADDR_W.

Ports:
- vga_clk  in  1  pixel clock; all state updates on posedge.
- reset_n  in  1  asynchronous active-low reset.
- frame_start  in  1  one-cycle pulse per video frame (vsync edge).
- DrawX  in  10  current pixel x.
- DrawY  in  10  current pixel y.
- knight_x  in  10  sprite top-left x.
- knight_y  in  10  sprite top-left y.
- move  in  1  level; knight is walking.
- attack_req  in  1  one-cycle request pulse.
- facing_left  in  1  mirror request.
- rom_address  out  ADDR_W  address to the sprite ROM.
- sprite_on  out  1  current pixel lies inside the sprite box.
- anim_state  out  2  0=IDLE, 1=WALK, 2=ATTACK.
- frame_idx  out  3  frame index within the current strip.
- attack_busy  out  1  high while in ATTACK.

Behaviour:
- Reset (async, reset_n=0): anim_state=IDLE, frame_idx=0, tick counter=0, attack pending flag=0, rom_address=0, sprite_on=0, attack_busy=0.
- Attack pending flag:
  - Set by attack_req when not in ATTACK.
  - Cleared at the next frame_start.
  - attack_req while in ATTACK is dropped.
  - If attack_req and frame_start coincide, the request is taken at that same frame_start.
- State machine and counters change only on cycles where frame_start=1.
  - IDLE: pending attack -> ATTACK; else move=1 -> WALK; else stay.
  - WALK: pending attack -> ATTACK; else move=0 -> IDLE; else stay.
  - ATTACK: non-interruptible. After the last attack frame has completed its ticks, go to WALK if move=1, else IDLE.
  - On any state change, frame_idx=0 and tick=0.
  - Otherwise tick increments. When tick==TICKS_PER_FRAME-1, tick wraps to 0 and frame_idx advances, wrapping to 0 after the strip's last frame.
- Address path, 1-cycle registered latency from DrawX/DrawY:
  - lx = DrawX - knight_x and ly = DrawY - knight_y, computed 11-bit signed.
  - in_box = 0<=lx<SPR_W and 0<=ly<SPR_H.
  - col = lx, or SPR_W-1-lx when mirrored.
  - rom_address = (strip_base + frame_idx)*SPR_W*SPR_H + ly*SPR_W + col.
  - With defaults, ly*30 is implemented as (ly<<5)-(ly<<1); no generic multiplier.
  - When in_box=0: rom_address=0 and sprite_on=0.
- Edge placement: the box may be clipped by the screen edge. A negative lx/ly, or knight_x>609, is handled by the signed compare with no wrap-around artefacts.
- Mid-frame state changes are impossible by construction, since state only moves at frame_start.
- Reset mid-attack returns to IDLE immediately.

Optional Feature:
- Macro: KNIGHT_HFLIP_EN.
- Defined: facing_left=1 mirrors the column (col = SPR_W-1-lx).
- Undefined: facing_left is ignored and col = lx always. The port remains in the interface.

Decomposition:
- Package knight_anim_pkg:
  - anim_state_t enum {IDLE, WALK, ATTACK}.
  - Strip base constants IDLE_BASE=0, WALK_BASE=4, ATK_BASE=10.
  - FRAME_PIX = SPR_W*SPR_H.
- Sub-module knight_addr_gen: combinational box test, mirror and address arithmetic. The top holds the FSM, counters and output registers.

Test Plan:
- Reset, then 30 frame_start pulses with move=0 -> frame_idx sequence 0,1,2,3,0 changing every 6 pulses; anim_state=0.
- move=1 held, then frame_start -> anim_state=1, frame_idx=0. After 36 pulses frame_idx has wrapped 5->0; at frame 2 the address for (lx=0,ly=0) is 6*1920 = 11520.
- attack_req pulse coincident with frame_start in WALK -> ATTACK at that pulse. After 18 pulses: WALK if move=1, else IDLE. A second attack_req mid-attack is ignored (attack lasts 18 pulses, not 36).
- knight_x=100, knight_y=200, IDLE frame 0; DrawX=105, DrawY=210 -> next cycle rom_address=305, sprite_on=1. DrawX=130 -> sprite_on=0, rom_address=0.
- KNIGHT_HFLIP_EN defined, facing_left=1, same pixel -> rom_address = 10*30+24 = 324. Macro undefined -> 305.
- reset_n asserted asynchronously mid-ATTACK, between clock edges -> outputs go to reset values immediately. After release, the first frame_start with move=0 keeps IDLE and frame_idx=0.

Source files
------------

// File: rtl/knight_anim_pkg.sv
// rtl/knight_anim_pkg.sv - shared constants, state type and strip helpers for the knight sequencer
// Purpose: sprite geometry, ROM strip layout and animation timing used by RTL and bench.
// Ports: none (package).
package knight_anim_pkg;

  localparam int SPR_W           = 30;
  localparam int SPR_H           = 64;
  localparam int IDLE_FRAMES     = 4;
  localparam int WALK_FRAMES     = 6;
  localparam int ATTACK_FRAMES   = 3;
  localparam int TICKS_PER_FRAME = 6;
  localparam int ADDR_W          = 15;
  localparam int FRAME_PIX       = SPR_W * SPR_H;

  // First ROM frame of each animation strip.
  localparam logic [3:0] IDLE_BASE = 4'd0;
  localparam logic [3:0] WALK_BASE = 4'd4;
  localparam logic [3:0] ATK_BASE  = 4'd10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WALK   = 2'd1,
    ATTACK = 2'd2
  } anim_state_t;

  function automatic logic [3:0] strip_base(input logic [1:0] st);
    case (st)
      2'd1:    strip_base = WALK_BASE;
      2'd2:    strip_base = ATK_BASE;
      default: strip_base = IDLE_BASE;
    endcase
  endfunction

  function automatic logic [2:0] strip_last(input logic [1:0] st);
    case (st)
      2'd1:    strip_last = 3'(WALK_FRAMES - 1);
      2'd2:    strip_last = 3'(ATTACK_FRAMES - 1);
      default: strip_last = 3'(IDLE_FRAMES - 1);
    endcase
  endfunction

endpackage

// File: rtl/knight_anim_sequencer_if.sv
// rtl/knight_anim_sequencer_if.sv - game/video side bundle for the knight sequencer
// Purpose: groups game-logic inputs, raster position and ROM-side outputs.
// Modports: master = game/video logic (drives inputs), slave = sequencer.
interface knight_anim_sequencer_if;
  import knight_anim_pkg::*;

  logic              frame_start;
  logic [9:0]        DrawX;
  logic [9:0]        DrawY;
  logic [9:0]        knight_x;
  logic [9:0]        knight_y;
  logic              move;
  logic              attack_req;
  logic              facing_left;
  logic [ADDR_W-1:0] rom_address;
  logic              sprite_on;
  logic [1:0]        anim_state;
  logic [2:0]        frame_idx;
  logic              attack_busy;

  modport master (
    output frame_start, DrawX, DrawY, knight_x, knight_y, move, attack_req, facing_left,
    input  rom_address, sprite_on, anim_state, frame_idx, attack_busy
  );

  modport slave (
    input  frame_start, DrawX, DrawY, knight_x, knight_y, move, attack_req, facing_left,
    output rom_address, sprite_on, anim_state, frame_idx, attack_busy
  );

endinterface

// File: rtl/knight_addr_gen.sv
// rtl/knight_addr_gen.sv - combinational bounding-box test, mirror and sprite ROM address
// Purpose: maps the raster position into the knight's box and forms the ROM address.
// Config: KNIGHT_HFLIP_EN enables horizontal mirroring via i_facing_left.
// Ports: i_draw_x/i_draw_y raster pixel, i_knight_x/i_knight_y box top-left,
//        i_facing_left mirror request, i_frame_sel absolute ROM frame,
//        o_in_box pixel inside box, o_addr ROM address (0 outside box).
module knight_addr_gen
  import knight_anim_pkg::*;
(
  input  logic [9:0]        i_draw_x,
  input  logic [9:0]        i_draw_y,
  input  logic [9:0]        i_knight_x,
  input  logic [9:0]        i_knight_y,
  input  logic              i_facing_left,
  input  logic [3:0]        i_frame_sel,
  output logic              o_in_box,
  output logic [ADDR_W-1:0] o_addr
);

  logic [10:0]       w_lx;
  logic [10:0]       w_ly;
  logic              w_in_x;
  logic              w_in_y;
  logic              w_mirror;
  logic [4:0]        w_col;
  logic [5:0]        w_row;
  logic [ADDR_W-1:0] w_row_off;
  logic [ADDR_W-1:0] w_frame_off;

  // 11-bit two's complement difference: bit 10 marks pixels left of / above the box,
  // so clipped placements never wrap into the box.
  assign w_lx   = {1'b0, i_draw_x} - {1'b0, i_knight_x};
  assign w_ly   = {1'b0, i_draw_y} - {1'b0, i_knight_y};
  assign w_in_x = !w_lx[10] && (w_lx[9:0] < 10'(SPR_W));
  assign w_in_y = !w_ly[10] && (w_ly[9:0] < 10'(SPR_H));
  assign o_in_box = w_in_x && w_in_y;

`ifdef KNIGHT_HFLIP_EN
  assign w_mirror = i_facing_left;
`else
  // Port stays in the bundle; mirroring is compiled out.
  assign w_mirror = i_facing_left & 1'b0;
`endif

  assign w_col = w_mirror ? (5'(SPR_W - 1) - w_lx[4:0]) : w_lx[4:0];
  assign w_row = w_ly[5:0];

  // row*30 = row*32 - row*2 ; frame*1920 = frame*2048 - frame*128
  assign w_row_off   = ADDR_W'({w_row, 5'b0}) - ADDR_W'({w_row, 1'b0});
  assign w_frame_off = ADDR_W'({i_frame_sel, 11'b0}) - ADDR_W'({i_frame_sel, 7'b0});

  assign o_addr = o_in_box ? (w_frame_off + w_row_off + ADDR_W'(w_col)) : '0;

endmodule

// File: rtl/knight_anim_sequencer.sv
// rtl/knight_anim_sequencer.sv - knight animation FSM and registered sprite ROM address
// Purpose: idle/walk/attack state, frame/tick counters, attack latch, registered address path.
// Config: KNIGHT_HFLIP_EN (inside knight_addr_gen) enables facing_left mirroring.
// Ports: vga_clk pixel clock, reset_n async active-low reset,
//        bus (slave) frame_start, DrawX/DrawY, knight_x/knight_y, move, attack_req,
//        facing_left in; rom_address, sprite_on, anim_state, frame_idx, attack_busy out.
module knight_anim_sequencer
  import knight_anim_pkg::*;
(
  input  logic                    vga_clk,
  input  logic                    reset_n,
  knight_anim_sequencer_if.slave  bus
);

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_WALK    = 2'(WALK);
  localparam logic [1:0] S_ATTACK  = 2'(ATTACK);
  localparam logic [2:0] LAST_TICK = 3'(TICKS_PER_FRAME - 1);

  logic [1:0]        r_state;
  logic [2:0]        r_frame_idx;
  logic [2:0]        r_tick;
  logic              r_atk_pend;
  logic [ADDR_W-1:0] r_rom_address;
  logic              r_sprite_on;

  logic              w_take_atk;
  logic              w_frame_done;
  logic              w_strip_done;
  logic [1:0]        w_next_state;
  logic [3:0]        w_frame_sel;
  logic              w_in_box;
  logic [ADDR_W-1:0] w_addr;

  // A request arriving on the frame_start cycle itself is honoured immediately.
  assign w_take_atk   = (r_atk_pend | bus.attack_req) & (r_state != S_ATTACK);
  assign w_frame_done = (r_tick == LAST_TICK);
  assign w_strip_done = w_frame_done & (r_frame_idx == strip_last(r_state));

  always_comb begin
    w_next_state = S_IDLE;
    case (r_state)
      S_IDLE:   w_next_state = w_take_atk ? S_ATTACK : (bus.move ? S_WALK : S_IDLE);
      S_WALK:   w_next_state = w_take_atk ? S_ATTACK : (bus.move ? S_WALK : S_IDLE);
      S_ATTACK: w_next_state = w_strip_done ? (bus.move ? S_WALK : S_IDLE) : S_ATTACK;
      default:  w_next_state = S_IDLE;
    endcase
  end

  assign w_frame_sel = strip_base(r_state) + {1'b0, r_frame_idx};

  knight_addr_gen u_addr_gen (
    .i_draw_x      (bus.DrawX),
    .i_draw_y      (bus.DrawY),
    .i_knight_x    (bus.knight_x),
    .i_knight_y    (bus.knight_y),
    .i_facing_left (bus.facing_left),
    .i_frame_sel   (w_frame_sel),
    .o_in_box      (w_in_box),
    .o_addr        (w_addr)
  );

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= S_IDLE;
      r_frame_idx   <= 3'd0;
      r_tick        <= 3'd0;
      r_atk_pend    <= 1'b0;
      r_rom_address <= '0;
      r_sprite_on   <= 1'b0;
    end else begin
      r_rom_address <= w_addr;
      r_sprite_on   <= w_in_box;
      if (bus.frame_start) begin
        r_atk_pend <= 1'b0;
        r_state    <= w_next_state;
        if (w_next_state != r_state) begin
          r_frame_idx <= 3'd0;
          r_tick      <= 3'd0;
        end else if (w_frame_done) begin
          r_tick      <= 3'd0;
          r_frame_idx <= (r_frame_idx == strip_last(r_state)) ? 3'd0 : r_frame_idx + 3'd1;
        end else begin
          r_tick <= r_tick + 3'd1;
        end
      end else if (bus.attack_req && (r_state != S_ATTACK)) begin
        r_atk_pend <= 1'b1;
      end
    end
  end

  assign bus.rom_address = r_rom_address;
  assign bus.sprite_on   = r_sprite_on;
  assign bus.anim_state  = r_state;
  assign bus.frame_idx   = r_frame_idx;
  assign bus.attack_busy = (r_state == S_ATTACK);

endmodule

// File: tb/tb_knight_anim_sequencer.sv
// tb/tb_knight_anim_sequencer.sv - scoreboard bench for knight_anim_sequencer
module tb_knight_anim_sequencer;
  import knight_anim_pkg::*;

  logic vga_clk = 1'b0;
  logic reset_n = 1'b0;

  knight_anim_sequencer_if bus ();

  knight_anim_sequencer dut (
    .vga_clk (vga_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 vga_clk = ~vga_clk;

  typedef struct {
    int addr;
    int on;
    int st;
    int idx;
    int busy;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  // Reference: state plus number of frame_start pulses spent in it.
  int m_st   = 0;
  int m_cnt  = 0;
  int m_pend = 0;

  function automatic int s_len(int s);
    return (s == 1) ? 6 : (s == 2) ? 3 : 4;
  endfunction

  function automatic int s_base(int s);
    return (s == 1) ? 4 : (s == 2) ? 10 : 0;
  endfunction

  task automatic check(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s at %0t: got=%0d expected=%0d", name, $time, act, exp);
    end
  endtask

  function automatic exp_t reset_rec();
    exp_t e;
    e.addr = 0; e.on = 0; e.st = 0; e.idx = 0; e.busy = 0;
    return e;
  endfunction

  // Called right after a posedge with the inputs that edge consumed.
  task automatic model_step();
    exp_t e;
    int lx, ly, col, nxt;
    bit atk;
    if (!reset_n) begin
      m_st = 0; m_cnt = 0; m_pend = 0;
      q.push_back(reset_rec());
      return;
    end
    lx = int'(bus.DrawX) - int'(bus.knight_x);
    ly = int'(bus.DrawY) - int'(bus.knight_y);
    e.on = (lx >= 0 && lx < 30 && ly >= 0 && ly < 64) ? 1 : 0;
    col = lx;
`ifdef KNIGHT_HFLIP_EN
    if (bus.facing_left) col = 29 - lx;
`endif
    e.addr = e.on ? (s_base(m_st) + (m_cnt / 6) % s_len(m_st)) * 1920 + ly * 30 + col : 0;

    atk = (m_pend != 0 || bus.attack_req) && m_st != 2;
    if (bus.frame_start) begin
      if (m_st == 2) nxt = (m_cnt + 1 == 18) ? (bus.move ? 1 : 0) : 2;
      else if (atk)  nxt = 2;
      else           nxt = bus.move ? 1 : 0;
      if (nxt != m_st) begin
        m_st = nxt; m_cnt = 0;
      end else begin
        m_cnt++;
      end
      m_pend = 0;
    end else if (bus.attack_req && m_st != 2) begin
      m_pend = 1;
    end
    e.st   = m_st;
    e.idx  = (m_cnt / 6) % s_len(m_st);
    e.busy = (m_st == 2) ? 1 : 0;
    q.push_back(e);
  endtask

  task automatic cyc(bit fs, bit mv, bit ar, bit fl, int dx, int dy);
    bus.frame_start = fs;
    bus.move        = mv;
    bus.attack_req  = ar;
    bus.facing_left = fl;
    bus.DrawX       = 10'(dx);
    bus.DrawY       = 10'(dy);
    @(posedge vga_clk);
    model_step();
    #1;
  endtask

  function automatic int near(int k, int w);
    int v;
    v = k - 5 + int'($urandom_range(0, w + 9));
    if (v < 0) v = 0;
    if (v > 1023) v = 1023;
    return v;
  endfunction

  task automatic run_pulses(int n, bit mv, int atk_pulse, int mid_pulse);
    for (int p = 0; p < n; p++) begin
      for (int c = 0; c < 3; c++)
        cyc(1'b0, mv, (p == mid_pulse && c == 1), 1'($urandom_range(0, 1)),
            near(int'(bus.knight_x), 30), near(int'(bus.knight_y), 64));
      cyc(1'b1, mv, (p == atk_pulse), 1'($urandom_range(0, 1)),
          near(int'(bus.knight_x), 30), near(int'(bus.knight_y), 64));
    end
  endtask

  // Monitor: one expected record per sampled negedge.
  initial begin
    exp_t e;
    forever begin
      @(negedge vga_clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("rom_address", int'(bus.rom_address), e.addr);
        check("sprite_on",   int'(bus.sprite_on),   e.on);
        check("anim_state",  int'(bus.anim_state),  e.st);
        check("frame_idx",   int'(bus.frame_idx),   e.idx);
        check("attack_busy", int'(bus.attack_busy), e.busy);
      end
    end
  end

  initial begin
    bit mv;
    bus.frame_start = 1'b0;
    bus.move        = 1'b0;
    bus.attack_req  = 1'b0;
    bus.facing_left = 1'b0;
    bus.DrawX       = 10'd0;
    bus.DrawY       = 10'd0;
    bus.knight_x    = 10'd100;
    bus.knight_y    = 10'd200;

    repeat (3) cyc(1'b0, 1'b0, 1'b0, 1'b0, 105, 210);
    reset_n = 1'b1;

    // Directed pixel in IDLE frame 0: 305, mirrored 324 when enabled, outside box 0.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 105, 210);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 105, 210);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 130, 210);

    run_pulses(30, 1'b0, -1, -1);        // idle strip cycling
    run_pulses(40, 1'b1, -1, -1);        // walk strip wrap
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 100, 200);
    run_pulses(25, 1'b1, 0, 5);          // coincident attack, mid-attack request dropped
    run_pulses(25, 1'b0, 2, 8);          // attack ends into idle
    run_pulses(10, 1'b1, -1, 3);         // latched request between pulses

    bus.knight_x = 10'd615; bus.knight_y = 10'd0;
    run_pulses(10, 1'b0, -1, -1);
    bus.knight_x = 10'd3;   bus.knight_y = 10'd2;
    run_pulses(10, 1'b1, -1, -1);
    bus.knight_x = 10'd1010; bus.knight_y = 10'd990;
    run_pulses(5, 1'b0, -1, -1);

    mv = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      if (i % 100 == 0) begin
        bus.knight_x = 10'($urandom_range(0, 1023));
        bus.knight_y = 10'($urandom_range(0, 1023));
      end
      if ($urandom_range(0, 40) == 0) mv = ~mv;
      cyc(($urandom_range(0, 3) == 0), mv, ($urandom_range(0, 15) == 0),
          1'($urandom_range(0, 1)), near(int'(bus.knight_x), 30), near(int'(bus.knight_y), 64));
    end

    // Asynchronous reset in the middle of an attack.
    bus.knight_x = 10'd100; bus.knight_y = 10'd200;
    run_pulses(1, 1'b0, 0, -1);
    run_pulses(3, 1'b0, -1, -1);
    reset_n = 1'b0;
    m_st = 0; m_cnt = 0; m_pend = 0;
    void'(q.pop_back());
    q.push_back(reset_rec());
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 105, 210);
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 105, 210);
    reset_n = 1'b1;
    run_pulses(1, 1'b0, -1, -1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 105, 210);

    repeat (3) @(negedge vga_clk);
    check("queue_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
